// File: rtl/timer_pkg.sv
// Shared definitions for the 6530-style interval timer sequencer:
// prescaler encodings, timer address bit positions and FSM states.
package timer_pkg;

  typedef enum logic [1:0] {
    DIV1    = 2'b00,
    DIV8    = 2'b01,
    DIV64   = 2'b10,
    DIV1024 = 2'b11
  } presel_e;

  localparam int unsigned IRQ_EN_BIT   = 2;
  localparam int unsigned READ_SEL_BIT = 0;
  localparam int unsigned MAX_DELAY    = 262144;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    WRITE,
    WAIT_IRQ,
    ACK,
    CAPT
  } state_e;

endpackage

// File: rtl/timer_sequencer_if.sv
// Timer register bus as seen from the CPU side: one chip-enable strobe per
// access, registered read data with output-enable, and the active-low irq.
interface timer_sequencer_if;
  logic       bus_en;
  logic       bus_we_n;
  logic [2:0] bus_a;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       bus_oe;
  logic       irq_n;

  modport master (
    output bus_en, bus_we_n, bus_a, bus_wdata,
    input  bus_rdata, bus_oe, irq_n
  );

  modport slave (
    input  bus_en, bus_we_n, bus_a, bus_wdata,
    output bus_rdata, bus_oe, irq_n
  );
endinterface

// File: rtl/timer_presel.sv
// Maps a delay in ticks to the smallest prescaler whose rounded-up count
// fits in 256, plus the 8-bit count to load (256 encodes as 8'h00).
module timer_presel
  import timer_pkg::*;
#(
  parameter int unsigned DLY_W = 19
) (
  input  logic [DLY_W-1:0] delay,
  output logic             valid,
  output presel_e          sel,
  output logic [7:0]       count
);

  localparam logic [DLY_W:0] LIM1    = (DLY_W+1)'(256);
  localparam logic [DLY_W:0] LIM8    = (DLY_W+1)'(2048);
  localparam logic [DLY_W:0] LIM64   = (DLY_W+1)'(16384);
  localparam logic [DLY_W:0] LIM_MAX = (DLY_W+1)'(MAX_DELAY);
  localparam logic [DLY_W:0] RND8    = (DLY_W+1)'(7);
  localparam logic [DLY_W:0] RND64   = (DLY_W+1)'(63);
  localparam logic [DLY_W:0] RND1024 = (DLY_W+1)'(1023);

  // One spare bit so the round-up addition can never wrap.
  logic [DLY_W:0] d_ext;
  assign d_ext = {1'b0, delay};

  always_comb begin
    valid = (d_ext != '0) && (d_ext <= LIM_MAX);
    if (d_ext <= LIM1) begin
      sel   = DIV1;
      count = 8'(d_ext);
    end else if (d_ext <= LIM8) begin
      sel   = DIV8;
      count = 8'((d_ext + RND8) >> 3);
    end else if (d_ext <= LIM64) begin
      sel   = DIV64;
      count = 8'((d_ext + RND64) >> 6);
    end else begin
      sel   = DIV1024;
      count = 8'((d_ext + RND1024) >> 10);
    end
  end

endmodule

// File: rtl/timer_sequencer.sv
// CPU-side initiator for one interval timer: programs a delay, waits for the
// irq (or timeout/cancel), disarms with a counter read and reports done/err.
module timer_sequencer
  import timer_pkg::*;
#(
  parameter int unsigned DLY_W   = 19,
  parameter int unsigned TIMEOUT = 300000,
  parameter int unsigned TO_W    = 19
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [DLY_W-1:0]   req_delay,
  input  logic               cancel,
  output logic               done,
  output logic               err,
  output logic [7:0]         rd_value,
  timer_sequencer_if.master  bus
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [DLY_W-1:0]  delay_q, delay_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              abort_q, abort_d;
  logic              req_ready_q, req_ready_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [7:0]        rd_value_q, rd_value_d;
  logic              bus_en_q, bus_en_d;
  logic              bus_we_n_q, bus_we_n_d;
  logic [2:0]        bus_a_q, bus_a_d;
  logic [7:0]        bus_wdata_q, bus_wdata_d;

  logic              pre_valid;
  presel_e           pre_sel;
  logic [7:0]        pre_count;

  timer_presel #(.DLY_W(DLY_W)) u_presel (
    .delay (delay_q),
    .valid (pre_valid),
    .sel   (pre_sel),
    .count (pre_count)
  );

  always_comb begin
    state_d     = state_q;
    delay_d     = delay_q;
    to_cnt_d    = to_cnt_q;
    abort_d     = abort_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    rd_value_d  = rd_value_q;
    bus_wdata_d = bus_wdata_q;
    bus_a_d     = '0;

    unique case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (req_valid) begin
          delay_d = req_delay;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cancel) begin
          abort_d = 1'b1;
          state_d = ACK;
        end else if (!pre_valid) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          bus_wdata_d = pre_count;
          state_d     = WRITE;
        end
      end
      // A cancel seen during the write is parked for one WAIT_IRQ cycle so the
      // disarming read never lands right after the write strobe.
      WRITE: begin
        to_cnt_d = '0;
        state_d  = WAIT_IRQ;
        if (cancel) abort_d = 1'b1;
      end
      WAIT_IRQ: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (abort_q || cancel) begin
          abort_d = 1'b1;
          state_d = ACK;
        end else if (!bus.irq_n) begin
          state_d = ACK;
        end else if (to_cnt_d == TO_LAST) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      ACK: state_d = CAPT;
      CAPT: begin
        rd_value_d = bus.bus_oe ? bus.bus_rdata : 8'h00;
        done_d     = 1'b1;
        err_d      = abort_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Bus outputs are registered against the state being entered.
    bus_en_d   = (state_d == WRITE) || (state_d == ACK);
    bus_we_n_d = (state_d != WRITE);
    if (state_d == WRITE) begin
      bus_a_d[IRQ_EN_BIT] = 1'b1;
      bus_a_d[1:0]        = pre_sel;
    end else if (state_d == ACK) begin
      bus_a_d[READ_SEL_BIT] = 1'b0;
    end
    req_ready_d = (state_d == IDLE) && !done_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      delay_q     <= '0;
      to_cnt_q    <= '0;
      abort_q     <= 1'b0;
      req_ready_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_value_q  <= '0;
      bus_en_q    <= 1'b0;
      bus_we_n_q  <= 1'b1;
      bus_a_q     <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      delay_q     <= delay_d;
      to_cnt_q    <= to_cnt_d;
      abort_q     <= abort_d;
      req_ready_q <= req_ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rd_value_q  <= rd_value_d;
      bus_en_q    <= bus_en_d;
      bus_we_n_q  <= bus_we_n_d;
      bus_a_q     <= bus_a_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign done          = done_q;
  assign err           = err_q;
  assign rd_value      = rd_value_q;
  assign bus.bus_en    = bus_en_q;
  assign bus.bus_we_n  = bus_we_n_q;
  assign bus.bus_a     = bus_a_q;
  assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed bench for timer_sequencer with a behavioural timer read port and
// scoreboards for bus accesses and completions.
module tb_timer_sequencer;

  localparam int unsigned DLY_W   = 19;
  localparam int unsigned TIMEOUT = 20;
  localparam int unsigned TO_W    = 19;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             req_valid = 1'b0;
  logic             cancel    = 1'b0;
  logic [DLY_W-1:0] req_delay = '0;
  logic             req_ready;
  logic             done;
  logic             err;
  logic [7:0]       rd_value;

  timer_sequencer_if bus ();

  timer_sequencer #(.DLY_W(DLY_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_delay (req_delay),
    .cancel    (cancel),
    .done      (done),
    .err       (err),
    .rd_value  (rd_value),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       we_n;
    logic [2:0] a;
    logic [7:0] wdata;
  } bus_exp_t;

  typedef struct packed {
    logic       err;
    logic       chk_rd;
    logic [7:0] rd;
  } done_exp_t;

  bus_exp_t  bus_q[$];
  done_exp_t done_q[$];
  int        n_checks = 0;
  int        n_errors = 0;
  logic [7:0] tmr_val = 8'h00;
  logic       prev_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Timer read port: registered data one cycle after a read strobe.
  always @(posedge clk) begin
    if (!rst_n) begin
      bus.bus_oe    <= 1'b0;
      bus.bus_rdata <= 8'h00;
    end else begin
      bus.bus_oe    <= bus.bus_en && bus.bus_we_n;
      bus.bus_rdata <= (bus.bus_en && bus.bus_we_n) ? tmr_val : 8'h00;
    end
  end

  always @(negedge clk) begin
    if (bus.bus_en === 1'b1) begin
      chk("bus_en_gap", 32'(prev_en), 32'd0);
      chk("bus_access_expected", 32'(bus_q.size() != 0), 32'd1);
      if (bus_q.size() != 0) begin
        bus_exp_t e;
        e = bus_q.pop_front();
        chk("sb_bus_we_n", 32'(bus.bus_we_n), 32'(e.we_n));
        chk("sb_bus_a", 32'(bus.bus_a), 32'(e.a));
        if (!e.we_n) chk("sb_bus_wdata", 32'(bus.bus_wdata), 32'(e.wdata));
      end
    end
    if (done === 1'b1) begin
      chk("done_expected", 32'(done_q.size() != 0), 32'd1);
      if (done_q.size() != 0) begin
        done_exp_t d;
        d = done_q.pop_front();
        chk("sb_done_err", 32'(err), 32'(d.err));
        if (d.chk_rd) chk("sb_rd_value", 32'(rd_value), 32'(d.rd));
      end
    end
    prev_en = bus.bus_en;
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_bus_en"},    32'(bus.bus_en),    32'd0);
    chk({tag, "_bus_we_n"},  32'(bus.bus_we_n),  32'd1);
    chk({tag, "_bus_a"},     32'(bus.bus_a),     32'd0);
    chk({tag, "_bus_wdata"}, 32'(bus.bus_wdata), 32'd0);
    chk({tag, "_done"},      32'(done),          32'd0);
    chk({tag, "_err"},       32'(err),           32'd0);
    chk({tag, "_rd_value"},  32'(rd_value),      32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready),     32'd1);
  endtask

  // Called just after a negedge; returns at the negedge of the CALC cycle.
  task automatic send(input logic [DLY_W-1:0] d);
    int k;
    k = 0;
    while (req_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("req_ready_before_send", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_delay = d;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic run_ok(input logic [DLY_W-1:0] d, input logic [2:0] a,
                        input logic [7:0] wd, input int w, input logic [7:0] val);
    tmr_val = val;
    bus_q.push_back('{we_n: 1'b0, a: a, wdata: wd});
    bus_q.push_back('{we_n: 1'b1, a: 3'b000, wdata: 8'h00});
    done_q.push_back('{err: 1'b0, chk_rd: 1'b1, rd: val});
    send(d);
    @(negedge clk);
    chk("write_cycle", 32'({bus.bus_en, bus.bus_we_n}), 32'd2);
    repeat (w) @(negedge clk);
    bus.irq_n = 1'b0;
    @(negedge clk);
    chk("ack_cycle", 32'({bus.bus_en, bus.bus_we_n}), 32'd3);
    bus.irq_n = 1'b1;
    @(negedge clk);
    chk("capt_no_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_err", 32'(err), 32'd0);
    chk("done_rd_value", 32'(rd_value), 32'(val));
    chk("ready_low_on_done", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("done_single", 32'(done), 32'd0);
    chk("ready_after_done", 32'(req_ready), 32'd1);
  endtask

  task automatic run_bad(input logic [DLY_W-1:0] d);
    done_q.push_back('{err: 1'b1, chk_rd: 1'b0, rd: 8'h00});
    send(d);
    chk("bad_calc_no_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("bad_done", 32'(done), 32'd1);
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_no_bus", 32'(bus.bus_en), 32'd0);
    @(negedge clk);
    chk("bad_done_single", 32'(done), 32'd0);
    chk("bad_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    bus.irq_n = 1'b1;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(req_ready), 32'd1);

    run_ok(19'd100,    3'b100, 8'd100, 10, 8'hA5);
    run_ok(19'd300,    3'b101, 8'd38,  2,  8'h17);
    run_ok(19'd8,      3'b100, 8'd8,   1,  8'hC3);
    run_ok(19'd257,    3'b101, 8'd33,  3,  8'h01);
    run_ok(19'd262144, 3'b111, 8'h00,  1,  8'h7E);

    run_bad(19'd262145);
    run_bad(19'd0);

    // Timeout with irq_n held high.
    bus_q.push_back('{we_n: 1'b0, a: 3'b100, wdata: 8'd50});
    done_q.push_back('{err: 1'b1, chk_rd: 1'b0, rd: 8'h00});
    send(19'd50);
    @(negedge clk);
    chk("timeout_write", 32'({bus.bus_en, bus.bus_we_n}), 32'd2);
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("timeout_latency", 32'(cyc), 32'(TIMEOUT));
    chk("timeout_err", 32'(err), 32'd1);
    @(negedge clk);
    chk("timeout_ready", 32'(req_ready), 32'd1);

    // Cancel on the third WAIT_IRQ cycle.
    tmr_val = 8'h3C;
    bus_q.push_back('{we_n: 1'b0, a: 3'b101, wdata: 8'd125});
    bus_q.push_back('{we_n: 1'b1, a: 3'b000, wdata: 8'h00});
    done_q.push_back('{err: 1'b1, chk_rd: 1'b1, rd: 8'h3C});
    send(19'd1000);
    @(negedge clk);
    repeat (3) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_ack", 32'({bus.bus_en, bus.bus_we_n}), 32'd3);
    @(negedge clk);
    chk("cancel_capt_no_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("cancel_done", 32'(done), 32'd1);
    chk("cancel_err", 32'(err), 32'd1);
    chk("cancel_ready_low", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("cancel_ready_back", 32'(req_ready), 32'd1);

    // Reset pulse during WAIT_IRQ, then a normal request.
    bus_q.push_back('{we_n: 1'b0, a: 3'b100, wdata: 8'd100});
    send(19'd100);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midreset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("midreset_no_done", 32'(done), 32'd0);
    run_ok(19'd64, 3'b100, 8'd64, 2, 8'h5A);

    chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
    chk("done_q_drained", 32'(done_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/timer_sequencer.md
Name: timer_sequencer

Overview:
- Bus initiator for the 6530-style interval timer: the CPU-side end of the timer's register interface.
- Accepts a delay request in clock ticks and selects prescaler and count.
- Issues the timer write cycle, waits for the active-low timer IRQ, then issues the acknowledging read cycle.
- Reports completion or error to a client via a valid/ready request and a done pulse; sits between a control FSM and one timer instance.

Parameters:
- DLY_W, 19, width of the requested delay in ticks; max legal delay is 262144 = 256*1024.
- TIMEOUT, 300000, clocks allowed in WAIT_IRQ before an error is declared.
- TO_W, 19, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  client request strobe.
- req_ready  out  1  high only in IDLE.
- req_delay  in  DLY_W  requested delay in ticks, sampled on req_valid&req_ready.
- cancel  in  1  abort the outstanding request.
- done  out  1  one-cycle completion pulse.
- err  out  1  qualifies done: 1 = bad request, timeout or cancel.
- rd_value  out  8  timer count captured by the acknowledge read; valid with done.
- bus_en  out  1  timer chip-enable, one cycle per bus access.
- bus_we_n  out  1  0 = write, 1 = read.
- bus_a  out  3  A[2] = irq enable, A[1:0] = prescaler select on write; A[0]=0 selects a counter read.
- bus_wdata  out  8  write data to timer.
- bus_rdata  in  8  read data from timer.
- bus_oe  in  1  timer drives bus_rdata.
- irq_n  in  1  timer interrupt, active low.

Behaviour:
- Reset (rst_n=0 at posedge, any state):
  - State returns to IDLE.
  - bus_en=0, bus_we_n=1, bus_a=0, bus_wdata=0, done=0, err=0, rd_value=0, timeout counter=0.
  - A pending request is dropped with no done pulse.
- IDLE:
  - req_ready=1.
  - On req_valid, latch req_delay and go to CALC.
- CALC (1 cycle), with D = latched delay:
  - D==0 or D>262144: done=1, err=1, back to IDLE. No bus cycle.
  - Otherwise pick the smallest div in {1,8,64,1024}, sel 0..3 respectively, such that ceil(D/div) <= 256.
  - N = (D + div - 1) >> log2(div), computed at DLY_W+1 bits with no overflow.
  - bus_wdata = N[7:0]; N=256 encodes as 8'h00.
  - Go to WRITE.
- WRITE (1 cycle):
  - bus_en=1, bus_we_n=0, bus_a={1'b1, sel}.
  - Clear the timeout counter; go to WAIT_IRQ.
- WAIT_IRQ:
  - bus_en=0. Timeout counter increments each cycle.
  - irq_n sampled 0 → ACK.
  - Counter reaches TIMEOUT-1 with irq_n high → done=1, err=1, IDLE.
  - irq_n low and timeout on the same cycle: irq wins.
- ACK (1 cycle):
  - bus_en=1, bus_we_n=1, bus_a=3'b000. This counter read disables the timer irq.
  - Go to CAPT.
- CAPT (1 cycle):
  - The timer's registered read data arrives this cycle.
  - rd_value <= bus_rdata if bus_oe, else 8'h00.
  - done=1, err=0, IDLE.
- cancel:
  - Honoured in CALC, WRITE and WAIT_IRQ.
  - Next cycle issues the ACK read to disarm the timer, then CAPT reports done=1, err=1.
  - Ignored in IDLE, ACK and CAPT.
- Outputs are registered.
- Latency from the accepting edge to done: 5 cycles plus the timer interval (CALC, WRITE, ≥1 WAIT, ACK, CAPT).
- bus_en never asserts on two consecutive cycles.
- A new request is accepted no earlier than the cycle after done.

Decomposition:
- Shared package timer_pkg:
  - prescaler select encodings: DIV1=2'b00, DIV8=2'b01, DIV64=2'b10, DIV1024=2'b11.
  - address bit positions: IRQ_EN_BIT=2, READ_SEL_BIT=0.
  - MAX_DELAY=262144.
  - state enum {IDLE, CALC, WRITE, WAIT_IRQ, ACK, CAPT}.
- One natural sub-module: timer_presel, a combinational D→(sel, N) mapper, unit-testable alone.

Test Plan:
- D=100 → WRITE with bus_a=3'b100, bus_wdata=100; irq_n pulled low 10 cycles later → ACK read bus_a=3'b000, then done=1, err=0.
- D=300 → bus_a=3'b101, bus_wdata=38. D=8 → bus_a=3'b100, bus_wdata=8. D=257 → bus_a=3'b101, bus_wdata=33.
- D=262144 → bus_a=3'b111, bus_wdata=8'h00. D=262145 or D=0 → done=1, err=1 one cycle after accept, bus_en never asserted.
- irq_n held high, TIMEOUT=20 → done=1, err=1 exactly 20 cycles after WRITE; no ACK cycle.
- cancel asserted 3 cycles into WAIT_IRQ → ACK read next cycle, then done=1, err=1; req_ready returns high the cycle after.
- rst_n low for 1 cycle during WAIT_IRQ → all outputs at reset values next cycle, no done pulse, req_ready=1; a new request is then served normally.
